// File: rtl/hinge_loss_stream_mean_pkg.sv
// Shared types and width helpers for the streaming hinge-loss mean block.
// Build option: define HINGE_SQUARED_EN to reduce squared hinge (h*h >> FRAC_W) instead of h.
package hinge_loss_pkg;

   typedef enum logic [1:0] {IDLE, ACC, DIV, OUT} state_t;

`ifdef HINGE_SQUARED_EN
   localparam bit SQ_EN = 1'b1;
`else
   localparam bit SQ_EN = 1'b0;
`endif

   // Width of the per-beat value fed to the accumulator and of out_mean
   function automatic int unsigned hw_f(input int unsigned data_w, input int unsigned frac_w,
                                        input bit squared);
      return squared ? (2 * (data_w + 1) - frac_w) : (data_w + 1);
   endfunction

   function automatic int unsigned acc_w_f(input int unsigned data_w, input int unsigned frac_w,
                                           input int unsigned cnt_w, input bit squared);
      return hw_f(data_w, frac_w, squared) + cnt_w;
   endfunction

   function automatic int unsigned one_f(input int unsigned frac_w);
      return 32'd1 << frac_w;
   endfunction

endpackage

// File: rtl/hinge_loss_stream_mean_if.sv
// Beat input stream and per-frame result stream of hinge_loss_stream_mean.
interface hinge_loss_stream_mean_if
   import hinge_loss_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FRAC_W = 8,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned HW    = hw_f(DATA_W, FRAC_W, SQ_EN);
   localparam int unsigned ACC_W = acc_w_f(DATA_W, FRAC_W, CNT_W, SQ_EN);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_pred;
   logic              in_target;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [HW-1:0]     out_mean;
   logic [ACC_W-1:0]  out_sum;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;

   modport master (
      output in_valid, in_pred, in_target, in_last, out_ready,
      input  in_ready, out_valid, out_mean, out_sum, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_pred, in_target, in_last, out_ready,
      output in_ready, out_valid, out_mean, out_sum, out_count, out_ovf
   );

endinterface

// File: rtl/hinge_loss_stream_mean_div_seq.sv
// Restoring divider: one quotient bit per cycle, MSB first, NUM_W cycles after start.
module hinge_div_seq #(
   parameter int unsigned NUM_W = 33,
   parameter int unsigned DEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] quot
);
   localparam int unsigned BC_W = $clog2(NUM_W + 1);

   logic [DEN_W-1:0] rem_q;
   logic [DEN_W-1:0] den_q;
   logic [NUM_W-1:0] quot_q;
   logic [BC_W-1:0]  bits_q;
   logic [DEN_W:0]   trial;
   logic             fits;

   // quot_q doubles as the dividend shift register: its MSB feeds the remainder
   always_comb begin
      trial = {rem_q, quot_q[NUM_W-1]};
      fits  = (trial >= {1'b0, den_q});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         den_q  <= '0;
         quot_q <= '0;
         bits_q <= '0;
      end else if (start) begin
         rem_q  <= '0;
         den_q  <= den;
         quot_q <= num;
         bits_q <= BC_W'(NUM_W);
      end else if (busy) begin
         rem_q  <= fits ? DEN_W'(trial - {1'b0, den_q}) : trial[DEN_W-1:0];
         quot_q <= {quot_q[NUM_W-2:0], fits};
         bits_q <= bits_q - 1'b1;
      end
   end

   assign busy = (bits_q != '0);
   assign done = (bits_q == BC_W'(1));
   assign quot = quot_q;

endmodule

// File: rtl/hinge_loss_stream_mean.sv
// Per-frame mean of hinge loss max(0, ONE - y*pred) over an in_last-delimited beat stream.
// Build option: HINGE_SQUARED_EN switches the per-beat value to (h*h) >> FRAC_W.
module hinge_loss_stream_mean
   import hinge_loss_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned FRAC_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   hinge_loss_stream_mean_if.slave  bus
);
   localparam int unsigned HB    = DATA_W + 1;
   localparam int unsigned HW    = hw_f(DATA_W, FRAC_W, SQ_EN);
   localparam int unsigned ACC_W = acc_w_f(DATA_W, FRAC_W, CNT_W, SQ_EN);
   localparam logic signed [DATA_W+1:0] ONE_S = (DATA_W + 2)'(one_f(FRAC_W));

   state_t                   state_q, state_d;
   logic                     in_rdy, beat, out_v;
   logic signed [DATA_W:0]   pred_x, yp;
   logic signed [DATA_W+1:0] m;
   logic [HB-1:0]            h;
   logic [HW-1:0]            hv;
`ifdef HINGE_SQUARED_EN
   logic [2*HB-1:0]          sq;
`endif
   logic [ACC_W-1:0]         acc_q, acc_nx;
   logic [CNT_W-1:0]         cnt_q, cnt_nx;
   logic                     ovf_q, ovf_nx, cnt_sat;
   logic                     div_start, div_busy, div_done;
   logic [ACC_W-1:0]         div_quot;

   // One extra bit on yp lets -(-2^(DATA_W-1)) be represented exactly
   always_comb begin
      pred_x = {bus.in_pred[DATA_W-1], bus.in_pred};
      yp     = bus.in_target ? pred_x : -pred_x;
      m      = ONE_S - $signed({yp[DATA_W], yp});
      h      = m[DATA_W+1] ? '0 : m[DATA_W:0];
`ifdef HINGE_SQUARED_EN
      sq     = {{HB{1'b0}}, h} * {{HB{1'b0}}, h};
      hv     = HW'(sq >> FRAC_W);
`else
      hv     = h;
`endif
   end

   assign in_rdy    = !rst && !div_busy && (state_q == IDLE || state_q == ACC);
   assign beat      = bus.in_valid && in_rdy;
   assign div_start = beat && bus.in_last;
   assign out_v     = (state_q == OUT);

   // Divider is loaded with the post-beat totals so division starts on the last-beat edge
   always_comb begin
      cnt_sat = &cnt_q;
      acc_nx  = acc_q + ACC_W'(hv);
      cnt_nx  = cnt_sat ? cnt_q : cnt_q + 1'b1;
      ovf_nx  = ovf_q | cnt_sat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (beat) begin
         acc_q <= acc_nx;
         cnt_q <= cnt_nx;
         ovf_q <= ovf_nx;
      end else if (out_v && bus.out_ready) begin
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (beat) state_d = bus.in_last ? DIV : ACC;
         ACC:  if (beat && bus.in_last) state_d = DIV;
         DIV:  if (div_done) state_d = OUT;
         OUT:  if (bus.out_ready) state_d = IDLE;
      endcase
   end

   hinge_div_seq #(
      .NUM_W(ACC_W),
      .DEN_W(CNT_W)
   ) u_div (
      .clk  (clk),
      .rst  (rst),
      .start(div_start),
      .num  (acc_nx),
      .den  (cnt_nx),
      .busy (div_busy),
      .done (div_done),
      .quot (div_quot)
   );

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_v;
   assign bus.out_mean  = out_v ? HW'(div_quot) : '0;
   assign bus.out_sum   = out_v ? acc_q : '0;
   assign bus.out_count = out_v ? cnt_q : '0;
   assign bus.out_ovf   = out_v && ovf_q;

endmodule

// File: tb/tb_hinge_loss_stream_mean.sv
// Scoreboard bench for hinge_loss_stream_mean: random frames vs. an arithmetic reference model.
module tb_hinge_loss_stream_mean;
   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int CNT_W  = 16;
`ifdef HINGE_SQUARED_EN
   localparam int HW = 2 * (DATA_W + 1) - FRAC_W;
`else
   localparam int HW = DATA_W + 1;
`endif
   localparam int ACC_W = HW + CNT_W;

   typedef struct {
      longint mean;
      longint sum;
      longint cnt;
      bit     ovf;
      longint due;
   } exp_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   exp_t   sb[$];
   int     tests = 0;
   int     fails = 0;
   longint cyc = 0;
   longint f_sum = 0;
   longint f_cnt = 0;
   int     rdy_mode = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   hinge_loss_stream_mean_if #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) bus ();

   hinge_loss_stream_mean #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   function automatic longint hinge_ref(input logic [15:0] p, input bit t);
      longint pv = longint'($signed(p));
      longint mv = 256 - (t ? pv : -pv);
      longint hv = (mv < 0) ? 0 : mv;
`ifdef HINGE_SQUARED_EN
      return (hv * hv) >> 8;
`else
      return hv;
`endif
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void push_frame();
      exp_t e;
      e.sum  = f_sum;
      e.cnt  = f_cnt;
      e.mean = f_sum / f_cnt;
      e.ovf  = 1'b0;
      e.due  = cyc + ACC_W + 1;
      sb.push_back(e);
      f_sum = 0;
      f_cnt = 0;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send_beat(input logic [15:0] p, input bit t, input bit l);
      bit got = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_pred   = p;
      bus.in_target = t;
      bus.in_last   = l;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            got = 1'b1;
            f_sum += hinge_ref(p, t);
            f_cnt++;
            if (l) push_frame();
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if (!got) begin
         tests++;
         fails++;
         $display("FAIL beat_accept: in_ready never seen, required within 300 cycles");
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d results outstanding, required 0", sb.size());
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #2;
      case (rdy_mode)
         1:       bus.out_ready = 1'b0;
         2:       bus.out_ready = 1'b1;
         default: bus.out_ready = ($urandom_range(0, 2) != 0);
      endcase
   end

   // Monitor: latency on first valid cycle, stability while stalled, fields on accept
   logic   prev_v = 1'b0;
   longint h_mean, h_sum, h_cnt, h_ovf;
   always @(negedge clk) begin
      if (bus.out_valid) begin
         if (!prev_v) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out: out_valid=1 with no frame outstanding, required 0");
            end else begin
               check("latency_cycle", cyc, sb[0].due);
            end
            h_mean = longint'(bus.out_mean);
            h_sum  = longint'(bus.out_sum);
            h_cnt  = longint'(bus.out_count);
            h_ovf  = longint'(bus.out_ovf);
         end else begin
            check("hold_mean", longint'(bus.out_mean), h_mean);
            check("hold_sum", longint'(bus.out_sum), h_sum);
            check("hold_count", longint'(bus.out_count), h_cnt);
            check("hold_ovf", longint'(bus.out_ovf), h_ovf);
         end
         if (bus.out_ready && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("out_mean", longint'(bus.out_mean), e.mean);
            check("out_sum", longint'(bus.out_sum), e.sum);
            check("out_count", longint'(bus.out_count), e.cnt);
            check("out_ovf", longint'(bus.out_ovf), longint'(e.ovf));
         end
      end
      prev_v = bus.out_valid;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not complete, %0d failures so far", fails);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] p;
      bit          t;
      int          n;
      bus.in_valid  = 1'b0;
      bus.in_pred   = '0;
      bus.in_target = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", longint'(bus.in_ready), 0);
      check("rst_out_valid", longint'(bus.out_valid), 0);
      check("rst_out_mean", longint'(bus.out_mean), 0);
      check("rst_out_sum", longint'(bus.out_sum), 0);
      check("rst_out_count", longint'(bus.out_count), 0);
      check("rst_out_ovf", longint'(bus.out_ovf), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", longint'(bus.in_ready), 1);
      @(posedge clk);
      #1;

      // Directed frames
      send_beat(16'h0200, 1'b1, 1'b1);
      send_beat(16'h0080, 1'b1, 1'b0);
      send_beat(16'h0080, 1'b0, 1'b1);
      send_beat(16'h8000, 1'b1, 1'b1);
      send_beat(16'h8000, 1'b0, 1'b1);
      send_beat(16'd156, 1'b1, 1'b0);
      send_beat(16'd156, 1'b1, 1'b0);
      send_beat(16'd155, 1'b1, 1'b1);
      drain();

      // Random frames with idle gaps between beats
      for (int f = 0; f < 25; f++) begin
         n = $urandom_range(1, 6);
         for (int b = 0; b < n; b++) begin
            if ($urandom_range(0, 3) == 0) p = 16'($urandom);
            else                           p = 16'($urandom_range(0, 1200) - 600);
            t = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
            send_beat(p, t, b == n - 1);
         end
      end
      drain();

      // Stall the result and offer a beat while the output is held
      rdy_mode = 1;
      @(posedge clk);
      #1;
      send_beat(16'h0100, 1'b0, 1'b1);
      for (int i = 0; i < 200 && !bus.out_valid; i++) @(negedge clk);
      check("stall_out_valid", longint'(bus.out_valid), 1);
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b1;
      bus.in_pred   = 16'h0000;
      bus.in_target = 1'b1;
      bus.in_last   = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_in_ready", longint'(bus.in_ready), 0);
      end
      rdy_mode = 2;
      @(negedge clk);
      @(negedge clk);
      check("accept_after_release", longint'(bus.in_ready), 1);
      if (bus.in_ready) begin
         f_sum += hinge_ref(16'h0000, 1'b1);
         f_cnt++;
         push_frame();
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      drain();
      rdy_mode = 0;

      // Reset during the divide discards the frame
      send_beat(16'h0040, 1'b1, 1'b1);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      f_sum = 0;
      f_cnt = 0;
      @(negedge clk);
      check("mid_rst_in_ready", longint'(bus.in_ready), 0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("no_out_after_rst", longint'(bus.out_valid), 0);
      end
      @(posedge clk);
      #1;
      send_beat(16'h0000, 1'b1, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
